// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int REQ_DATA_W = 32;
  localparam int REQ_ADDR_W = 9;

  typedef enum logic [1:0] {
    ARB,
    LOCKED,
    RELEASE
  } state_t;

  typedef enum logic {
    PORT_CORE,
    PORT_EXT
  } port_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, ext and memory signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);

  logic                  core_req;
  logic                  core_we;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_funct3;
  logic                  core_gnt;
  logic                  core_stall;
  logic                  core_rvalid;
  logic [DATA_W-1:0]     core_rdata;

  logic                  ext_req;
  logic                  ext_we;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [2:0]            ext_funct3;
  logic                  ext_lock;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport arb (
    input  core_req, core_we, core_addr, core_wdata, core_funct3,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_funct3, ext_lock,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport host (
    output core_req, core_we, core_addr, core_wdata, core_funct3,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_funct3, ext_lock,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_req_mux.sv
// rtl/dmem_req_mux.sv - grant-driven mux of the two request structs onto the memory port
module dmem_req_mux
  import dmem_arbiter_pkg::*;
(
  input  req_t                  core,
  input  req_t                  ext,
  input  logic                  core_gnt,
  input  logic                  ext_gnt,
  output logic                  rd,
  output logic                  wr,
  output logic [REQ_ADDR_W-1:0] addr,
  output logic [REQ_DATA_W-1:0] wdata,
  output logic [2:0]            funct3
);

  req_t sel;

  // With no grant everything collapses to zero, including the strobes.
  always_comb begin
    sel = '0;
    if (core_gnt) begin
      sel = core;
    end else if (ext_gnt) begin
      sel = ext;
    end
  end

  assign rd     = sel.req & ~sel.we;
  assign wr     = sel.req & sel.we;
  assign addr   = sel.addr;
  assign wdata  = sel.wdata;
  assign funct3 = sel.funct3;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/ext arbiter for the single-ported data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = REQ_DATA_W,
  parameter int DM_ADDRESS = REQ_ADDR_W,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.arb bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_FULL = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_FULL   = LW'(LOCK_MAX);

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt, starve_next;
  logic [LW-1:0] lock_cnt, lock_next;
  logic          core_gnt, ext_gnt;
  logic          tag_valid;
  port_t         tag_owner;

  req_t                  core_r, ext_r;
  logic                  mux_rd, mux_wr;
  logic [REQ_ADDR_W-1:0] mux_addr;
  logic [REQ_DATA_W-1:0] mux_wdata;
  logic [2:0]            mux_funct3;

  always_comb begin
    state_next  = state;
    core_gnt    = 1'b0;
    ext_gnt     = 1'b0;
    lock_next   = '0;
    starve_next = starve_cnt;
    unique case (state)
      ARB: begin
        if (bus.ext_req && (!bus.core_req || starve_cnt == STARVE_FULL)) begin
          ext_gnt = 1'b1;
        end else begin
          core_gnt = bus.core_req;
        end
        // The entry grant is the first of the locked burst.
        if (ext_gnt && bus.ext_lock) begin
          lock_next  = LW'(1);
          state_next = (LOCK_MAX == 1) ? RELEASE : LOCKED;
        end
      end
      LOCKED: begin
        ext_gnt   = bus.ext_req;
        lock_next = lock_cnt + 1'b1;
        if (!bus.ext_req || !bus.ext_lock) begin
          lock_next  = '0;
          state_next = ARB;
        end else if (lock_next == LOCK_FULL) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        core_gnt   = bus.core_req;
        state_next = ARB;
      end
      default: state_next = ARB;
    endcase

    if (!bus.ext_req || ext_gnt) begin
      starve_next = '0;
    end else if (starve_cnt != STARVE_FULL) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      tag_valid  <= 1'b0;
      tag_owner  <= PORT_CORE;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      lock_cnt   <= lock_next;
      tag_valid  <= mux_rd;
      tag_owner  <= ext_gnt ? PORT_EXT : PORT_CORE;
    end
  end

  assign core_r = '{req: bus.core_req, we: bus.core_we, addr: REQ_ADDR_W'(bus.core_addr),
                    wdata: REQ_DATA_W'(bus.core_wdata), funct3: bus.core_funct3};
  assign ext_r  = '{req: bus.ext_req, we: bus.ext_we, addr: REQ_ADDR_W'(bus.ext_addr),
                    wdata: REQ_DATA_W'(bus.ext_wdata), funct3: bus.ext_funct3};

  dmem_req_mux u_mux (
    .core     (core_r),
    .ext      (ext_r),
    .core_gnt (core_gnt),
    .ext_gnt  (ext_gnt),
    .rd       (mux_rd),
    .wr       (mux_wr),
    .addr     (mux_addr),
    .wdata    (mux_wdata),
    .funct3   (mux_funct3)
  );

  assign bus.core_gnt    = core_gnt;
  assign bus.ext_gnt     = ext_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.mem_rd      = mux_rd;
  assign bus.mem_wr      = mux_wr;
  assign bus.mem_addr    = DM_ADDRESS'(mux_addr);
  assign bus.mem_wdata   = DATA_W'(mux_wdata);
  assign bus.mem_funct3  = mux_funct3;

  // Read data belongs to whichever port owned last cycle's read; the other side sees zero.
  assign bus.core_rvalid = tag_valid && (tag_owner == PORT_CORE);
  assign bus.ext_rvalid  = tag_valid && (tag_owner == PORT_EXT);
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata   = bus.ext_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [0:511];

  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

  dmem_arbiter #(
    .DATA_W     (32),
    .DM_ADDRESS (9),
    .STARVE_MAX (4),
    .LOCK_MAX   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.arb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      mem[9'h010] <= 32'hDEAD_BEEF;
      mem[9'h008] <= 32'hA5A5_0008;
    end
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic creq, input logic cwe, input logic [8:0] caddr,
                      input logic [31:0] cwd, input logic ereq, input logic ewe,
                      input logic elock, input logic [8:0] eaddr);
    @(negedge clk);
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cwd;
    bus.ext_req    = ereq;
    bus.ext_we     = ewe;
    bus.ext_lock   = elock;
    bus.ext_addr   = eaddr;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0);
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b1;
    checks = 0;
    errors = 0;
    bus.core_funct3 = 3'b010;
    bus.ext_funct3  = 3'b100;
    bus.ext_wdata   = 32'h0;
    idle();
    idle();
    reset = 1'b0;

    // reset state
    idle();
    chk("rst_core_gnt", 32'(bus.core_gnt), 32'd0);
    chk("rst_ext_gnt", 32'(bus.ext_gnt), 32'd0);
    chk("rst_rvalid", 32'({bus.core_rvalid, bus.ext_rvalid}), 32'd0);
    chk("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_funct3", 32'(bus.mem_funct3), 32'd0);
    chk("rst_rdata", bus.core_rdata | bus.ext_rdata, 32'd0);

    // core-only read
    step(1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0);
    chk("t1_core_gnt", 32'(bus.core_gnt), 32'd1);
    chk("t1_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h010);
    chk("t1_mem_funct3", 32'(bus.mem_funct3), 32'd2);
    chk("t1_stall0", 32'(bus.core_stall), 32'd0);
    idle();
    chk("t1_core_rvalid", 32'(bus.core_rvalid), 32'd1);
    chk("t1_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    chk("t1_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("t1_stall1", 32'(bus.core_stall), 32'd0);

    // starvation: four core grants, ext on the fifth, then core again
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b0, 9'h008);
      chk($sformatf("t2_core_gnt_%0d", i), 32'(bus.core_gnt), (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t2_ext_gnt_%0d", i), 32'(bus.ext_gnt), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t2_stall_%0d", i), 32'(bus.core_stall), (i == 4) ? 32'd1 : 32'd0);
      if (i == 5) begin
        chk("t2_ext_rvalid", 32'(bus.ext_rvalid), 32'd1);
        chk("t2_ext_rdata", bus.ext_rdata, 32'hA5A5_0008);
        chk("t2_core_rdata0", bus.core_rdata, 32'd0);
      end
    end
    idle();

    // lock bound: eight ext grants, release cycle to core, starvation regains ext
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b1, 9'h030);
    chk("t3_entry_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h030);
      chk($sformatf("t3_lock_ext_gnt_%0d", i), 32'(bus.ext_gnt), 32'd1);
      chk($sformatf("t3_lock_stall_%0d", i), 32'(bus.core_stall), 32'd1);
    end
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h030);
    chk("t3_release_core_gnt", 32'(bus.core_gnt), 32'd1);
    chk("t3_release_ext_gnt", 32'(bus.ext_gnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h030);
      chk($sformatf("t3_post_core_gnt_%0d", i), 32'(bus.core_gnt), 32'd1);
    end
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h030);
    chk("t3_starve_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("t3_starve_core_gnt", 32'(bus.core_gnt), 32'd0);
    idle();
    idle();

    // voluntary lock release after a burst of three
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b1, 9'h040);
    chk("t4_ext_gnt_0", 32'(bus.ext_gnt), 32'd1);
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h044);
    chk("t4_ext_gnt_1", 32'(bus.ext_gnt), 32'd1);
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b0, 9'h048);
    chk("t4_ext_gnt_2", 32'(bus.ext_gnt), 32'd1);
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b0, 9'h04C);
    chk("t4_core_gnt_3", 32'(bus.core_gnt), 32'd1);
    chk("t4_ext_gnt_3", 32'(bus.ext_gnt), 32'd0);
    idle();

    // core write followed by ext read of the same word
    step(1'b1, 1'b1, 9'h020, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 9'h0);
    chk("t5_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("t5_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0, 9'h020);
    chk("t5_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("t5_no_rvalid_after_write", 32'(bus.core_rvalid), 32'd0);
    idle();
    chk("t5_ext_rvalid", 32'(bus.ext_rvalid), 32'd1);
    chk("t5_ext_rdata", bus.ext_rdata, 32'h1234_5678);
    chk("t5_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    chk("t5_core_rdata", bus.core_rdata, 32'd0);

    // reset while locked with an ext read granted
    step(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b1, 9'h010);
    chk("t6_entry_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b1, 1'b0, 1'b1, 9'h010);
    reset = 1'b1;
    chk("t6_locked_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("t6_locked_mem_rd", 32'(bus.mem_rd), 32'd1);
    idle();
    chk("t6_no_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("t6_no_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    chk("t6_ext_rdata", bus.ext_rdata, 32'd0);
    chk("t6_strobes", 32'({bus.mem_rd, bus.mem_wr, bus.core_gnt, bus.ext_gnt}), 32'd0);
    reset = 1'b0;
    step(1'b1, 1'b0, 9'h004, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0);
    chk("t6_core_gnt_after_reset", 32'(bus.core_gnt), 32'd1);
    chk("t6_stall_after_reset", 32'(bus.core_stall), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-ported data memory between the pipeline MEM stage (core port) and an external loader/debug port (ext port). It issues at most one memory access per cycle and returns read data one cycle after the grant. It drives a stall back to the pipeline while the core is denied. Fairness comes from core priority, a starvation counter for ext, and a bounded ext lock for bursts.

## Interface
Parameters:
- DATA_W, 32, data width
- DM_ADDRESS, 9, memory address width
- STARVE_MAX, 4, consecutive ext denials before ext is forced a grant (≥1)
- LOCK_MAX, 8, max consecutive locked ext grants before forced release (≥1)

Ports:
- clk  in  1  clock; one clock domain only
- reset  in  1  synchronous, active-high
- core_req  in  1  core access request (MemRead|MemWrite of EX/MEM)
- core_we  in  1  1=write, 0=read
- core_addr  in  DM_ADDRESS  byte address
- core_wdata  in  DATA_W  store data
- core_funct3  in  3  access size/sign, passed through unchanged
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  read data for core valid
- core_rdata  out  DATA_W  read data
- ext_req, ext_we, ext_addr, ext_wdata, ext_funct3  in  same as core
- ext_lock  in  1  request to keep the grant on the following cycle
- ext_gnt, ext_rvalid  out  1;  ext_rdata  out  DATA_W
- mem_rd, mem_wr  out  1  memory strobes
- mem_addr  out  DM_ADDRESS;  mem_wdata  out  DATA_W;  mem_funct3  out  3
- mem_rdata  in  DATA_W  valid the cycle after mem_rd

## Operation
- Grants are combinational from the current requests and registered state. At most one gnt is high. The mem_* outputs mux the granted port. With no grant: mem_rd=mem_wr=0, and addr/wdata/funct3=0.
- FSM states:
  - ARB: core wins if core_req unless starve_cnt==STARVE_MAX, in which case ext wins. Ext wins if only ext requests.
  - ARB → LOCKED when ext is granted with ext_lock=1.
  - LOCKED: ext_req is granted and core is denied. lock_cnt counts granted ext cycles, including the entry cycle.
  - LOCKED → ARB when ext_req=0, or when ext_lock=0 on a granted cycle.
  - LOCKED → RELEASE when lock_cnt reaches LOCK_MAX.
  - RELEASE: ext is denied. Core is granted if it requests. Always returns to ARB next cycle.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 each cycle ext_req & ~ext_gnt.
  - Cleared on ext_gnt or ~ext_req.
  - Saturates at STARVE_MAX.
  - Denials in RELEASE also count.
- Read return: a registered tag {valid, owner} captures a granted read. Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other port's rdata=0. Writes produce no rvalid.
- Core write and ext read of the same address in consecutive cycles: memory order equals grant order. No reordering.

## Timing
- Reset values: FSM=ARB, starve_cnt=0, lock_cnt=0, read tag invalid. Therefore all gnt, rvalid, mem_rd, mem_wr = 0 and all data outputs = 0 in the cycle after reset.
- Reset asserted mid-lock or with a read in flight: the state is dropped and no rvalid is emitted the next cycle.
- Grant latency 0 cycles (same cycle as req when winning). Read data latency 1 cycle after gnt.
- core_stall is combinational. The pipeline must hold EX/MEM while it is high.
- Simultaneous requests in ARB with starve_cnt<STARVE_MAX: core wins.

## Structure
- A shared package holds:
  - the FSM state enum (ARB, LOCKED, RELEASE)
  - the port-id enum (PORT_CORE, PORT_EXT)
  - a request struct {req, we, addr, wdata, funct3}
- A sub-module `dmem_req_mux` is the natural split: a pure grant-driven mux of request structs onto mem_*. The FSM, counters and read tag stay in dmem_arbiter.

## Test plan
1. **Core only.** Core read at addr 0x010, memory returns 0xDEADBEEF. Expect core_gnt=1 and mem_rd=1 in cycle 0. Expect core_rvalid=1 and core_rdata=0xDEADBEEF in cycle 1. core_stall stays 0 throughout.
2. **Starvation.** Both request continuously, STARVE_MAX=4. Expect core granted 4 cycles, ext granted in the 5th cycle with core_stall=1, then core again.
3. **Lock bound.** ext_lock=1 held with ext_req, core_req=1, LOCK_MAX=8. Expect 8 ext grants, then a RELEASE cycle granting core, then ext regained only via starvation or when the core goes idle.
4. **Lock release.** Ext locked burst of 3 with ext_lock dropped on the 3rd grant. Expect a return to ARB and core granted on the 4th cycle.
5. **Ordering.** Core write 0x12345678 to 0x020, then ext read of 0x020 on the next cycle. Expect ext_rdata=0x12345678 and core_rvalid=0.
6. **Reset mid-operation.** Assert reset in LOCKED with an ext read granted. Expect no ext_rvalid next cycle, all outputs 0, FSM=ARB, and a core request granted the cycle after reset deasserts.
